// File: rtl/mem_resp_queue_if.sv
// mem_resp_queue_if: bundles the memory-stage request side, the data-bus
// response side and the write-back handshake of mem_resp_queue.
//   slave  : the queue itself (takes requests/responses, drives results).
//   master : the surrounding pipeline / test environment.
// Signals:
//   req_*       request accepted by the bus this cycle, plus load decode info
//   data_ok     in-order bus response, rdata valid with it
//   flush       kill every entry (pipeline redirect)
//   out_*       completed head entry towards WB (valid/ready)
//   outstanding unanswered live entries plus responses still to be dropped
//   proto_err   sticky: data_ok seen while nothing was owed
interface mem_resp_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int DEST_W = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              req_valid;
  logic              req_ready;
  logic              req_is_load;
  logic [6:0]        req_load_type;
  logic [1:0]        req_offset;
  logic [DATA_W-1:0] req_rt_value;
  logic              req_gr_we;
  logic [DEST_W-1:0] req_dest;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_gr_we;
  logic [DEST_W-1:0] out_dest;
  logic [CW-1:0]     outstanding;
  logic              proto_err;

  modport slave (
    input  req_valid, req_is_load, req_load_type, req_offset, req_rt_value,
           req_gr_we, req_dest, data_ok, rdata, flush, out_ready,
    output req_ready, out_valid, out_result, out_gr_we, out_dest,
           outstanding, proto_err
  );

  modport master (
    output req_valid, req_is_load, req_load_type, req_offset, req_rt_value,
           req_gr_we, req_dest, data_ok, rdata, flush, out_ready,
    input  req_ready, out_valid, out_result, out_gr_we, out_dest,
           outstanding, proto_err
  );
endinterface

// File: rtl/mem_resp_queue.sv
// mem_resp_queue: in-order tracker for up to DEPTH outstanding data-bus
// requests of the memory stage. Each accepted request is recorded at tail,
// in-order data_ok responses fill entries from resp, and the completed head
// entry is handed to WB with its load value extracted/merged
// (lb/lbu/lh/lhu/lw/lwl/lwr). A flush empties the queue and converts every
// response still owed into a drop count so late bus data is swallowed.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   bus          mem_resp_queue_if.slave (request, response, WB handshake)

// One queue slot: holds the request info, the filled flag and the read data.
module mem_resp_queue_slot #(
  parameter int INFO_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              alloc_i,
  input  logic [INFO_W-1:0] info_i,
  input  logic              fill_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              kill_i,
  output logic              vld_o,
  output logic              fil_o,
  output logic [INFO_W-1:0] info_o,
  output logic [DATA_W-1:0] rdata_o
);
  logic              vld_q, vld_d;
  logic              fil_q, fil_d;
  logic [INFO_W-1:0] info_q, info_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    vld_d   = vld_q;
    fil_d   = fil_q;
    info_d  = info_q;
    rdata_d = rdata_q;
    if (alloc_i) begin
      vld_d   = 1'b1;
      fil_d   = 1'b0;
      info_d  = info_i;
      rdata_d = '0;
    end
    if (fill_i) begin
      fil_d   = 1'b1;
      rdata_d = fill_data_i;
    end
    // pop or flush wins over everything else
    if (kill_i) begin
      vld_d = 1'b0;
      fil_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q   <= 1'b0;
      fil_q   <= 1'b0;
      info_q  <= '0;
      rdata_q <= '0;
    end else begin
      vld_q   <= vld_d;
      fil_q   <= fil_d;
      info_q  <= info_d;
      rdata_q <= rdata_d;
    end
  end

  assign vld_o   = vld_q;
  assign fil_o   = fil_q;
  assign info_o  = info_q;
  assign rdata_o = rdata_q;
endmodule

module mem_resp_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int DEST_W = 5
) (
  input  logic            clk,
  input  logic            resetn,
  mem_resp_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // load_type is one-hot {lb,lbu,lh,lhu,lw,lwl,lwr}, bit 6 = lb
  typedef struct packed {
    logic              is_load;
    logic [6:0]        ltype;
    logic [1:0]        off;
    logic [DATA_W-1:0] rt;
    logic              gr_we;
    logic [DEST_W-1:0] dest;
  } req_t;

  localparam int INFO_W = $bits(req_t);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] resp_q, resp_d;
  logic [CW-1:0] live_q, live_d;
  logic [CW-1:0] unresp_q, unresp_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          perr_q, perr_d;

  logic [DEPTH-1:0]             slot_vld;
  logic [DEPTH-1:0]             slot_fil;
  req_t [DEPTH-1:0]             slot_info;
  logic [DEPTH-1:0][DATA_W-1:0] slot_rdata;

  req_t              new_req;
  req_t              head_info;
  logic [DATA_W-1:0] head_rdata;
  logic [DATA_W-1:0] fill_data;
  logic [CW-1:0]     occ;
  logic [CW-1:0]     flush_drop;
  logic              req_ready, alloc, pop, out_valid;
  logic              dok_drop, dok_fill, dok_stray;

  assign new_req = '{bus.req_is_load, bus.req_load_type, bus.req_offset,
                     bus.req_rt_value, bus.req_gr_we, bus.req_dest};

  // Dropped responses still occupy capacity so a flushed burst cannot be
  // confused with fresh requests.
  assign occ       = live_q + drop_q;
  assign req_ready = occ < CW'(DEPTH);
  assign alloc     = bus.req_valid & req_ready;

  assign head_info  = slot_info[head_q];
  assign head_rdata = slot_rdata[head_q];
  assign out_valid  = slot_vld[head_q] & slot_fil[head_q];
  assign pop        = out_valid & bus.out_ready & ~bus.flush;

  // Owed flushed responses are consumed before any live entry is filled.
  assign dok_drop  = bus.data_ok & (drop_q != '0);
  assign dok_fill  = bus.data_ok & (drop_q == '0) & (unresp_q != '0);
  assign dok_stray = bus.data_ok & (drop_q == '0) & (unresp_q == '0);

  assign fill_data = slot_info[resp_q].is_load ? bus.rdata : '0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    mem_resp_queue_slot #(.INFO_W(INFO_W), .DATA_W(DATA_W)) u_slot (
      .clk        (clk),
      .resetn     (resetn),
      .alloc_i    (alloc & ~bus.flush & (tail_q == PW'(g))),
      .info_i     (new_req),
      .fill_i     (dok_fill & ~bus.flush & (resp_q == PW'(g))),
      .fill_data_i(fill_data),
      .kill_i     (bus.flush | (pop & (head_q == PW'(g)))),
      .vld_o      (slot_vld[g]),
      .fil_o      (slot_fil[g]),
      .info_o     (slot_info[g]),
      .rdata_o    (slot_rdata[g])
    );
  end

  // Net drop count on flush: everything unanswered, plus a request accepted
  // in the flush cycle, minus a response arriving in that same cycle.
  always_comb begin
    flush_drop = drop_q + unresp_q + CW'(alloc);
    if (bus.data_ok && flush_drop != '0) flush_drop = flush_drop - CW'(1);
  end

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    resp_d   = resp_q;
    live_d   = live_q;
    unresp_d = unresp_q;
    drop_d   = drop_q;
    perr_d   = perr_q;
    if (bus.flush) begin
      head_d   = tail_q;
      resp_d   = tail_q;
      live_d   = '0;
      unresp_d = '0;
      drop_d   = flush_drop;
      if (bus.data_ok && (drop_q + unresp_q + CW'(alloc)) == '0) perr_d = 1'b1;
    end else begin
      tail_d   = tail_q + PW'(alloc);
      head_d   = head_q + PW'(pop);
      resp_d   = resp_q + PW'(dok_fill);
      live_d   = live_q + CW'(alloc) - CW'(pop);
      unresp_d = unresp_q + CW'(alloc) - CW'(dok_fill);
      drop_d   = drop_q - CW'(dok_drop);
      if (dok_stray) perr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q   <= '0;
      tail_q   <= '0;
      resp_q   <= '0;
      live_q   <= '0;
      unresp_q <= '0;
      drop_q   <= '0;
      perr_q   <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      resp_q   <= resp_d;
      live_q   <= live_d;
      unresp_q <= unresp_d;
      drop_q   <= drop_d;
      perr_q   <= perr_d;
    end
  end

  function automatic logic [DATA_W-1:0] extract(req_t e, logic [DATA_W-1:0] r);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] t;
    logic [DATA_W-1:0] res;
    t = e.rt;
    case (e.off)
      2'd0:    b = r[7:0];
      2'd1:    b = r[15:8];
      2'd2:    b = r[23:16];
      default: b = r[31:24];
    endcase
    h   = e.off[1] ? r[31:16] : r[15:0];
    res = '0;
    if (e.is_load) begin
      if      (e.ltype[6]) res = {{24{b[7]}}, b};
      else if (e.ltype[5]) res = {24'b0, b};
      else if (e.ltype[4]) res = {{16{h[15]}}, h};
      else if (e.ltype[3]) res = {16'b0, h};
      else if (e.ltype[2]) res = r;
      else if (e.ltype[1]) begin
        case (e.off)
          2'd0:    res = {r[7:0],  t[23:0]};
          2'd1:    res = {r[15:0], t[15:0]};
          2'd2:    res = {r[23:0], t[7:0]};
          default: res = r;
        endcase
      end else if (e.ltype[0]) begin
        case (e.off)
          2'd0:    res = r;
          2'd1:    res = {t[31:24], r[31:8]};
          2'd2:    res = {t[31:16], r[31:16]};
          default: res = {t[31:8],  r[31:24]};
        endcase
      end
    end
    return res;
  endfunction

  assign bus.req_ready   = req_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_result  = out_valid ? extract(head_info, head_rdata) : '0;
  assign bus.out_gr_we   = out_valid & head_info.gr_we;
  assign bus.out_dest    = head_info.dest;
  assign bus.outstanding = unresp_q + drop_q;
  assign bus.proto_err   = perr_q;
endmodule

// File: tb/tb_mem_resp_queue.sv
// Bench for mem_resp_queue: directed stimulus, a queue-based reference model
// updated at every rising edge, a compare process on every falling edge and
// literal expectations at key points of each scenario.
module tb_mem_resp_queue;
  localparam int DEPTH = 4;
  localparam bit [6:0] LB  = 7'b1000000;
  localparam bit [6:0] LBU = 7'b0100000;
  localparam bit [6:0] LH  = 7'b0010000;
  localparam bit [6:0] LHU = 7'b0001000;
  localparam bit [6:0] LW  = 7'b0000100;
  localparam bit [6:0] LWL = 7'b0000010;
  localparam bit [6:0] LWR = 7'b0000001;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_resp_queue_if #(.DEPTH(DEPTH), .DATA_W(32), .DEST_W(5)) bus ();
  mem_resp_queue #(.DEPTH(DEPTH), .DATA_W(32), .DEST_W(5)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit        ld;
    bit [6:0]  ty;
    bit [1:0]  off;
    bit [31:0] rt;
    bit        we;
    bit [4:0]  dest;
    bit        filled;
    bit [31:0] rd;
  } ment_t;

  ment_t mq[$];
  int    m_drop = 0;
  bit    m_perr = 1'b0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] m_extract(ment_t e);
    bit [31:0] r, rt;
    bit [7:0]  b;
    bit [15:0] h;
    r  = e.rd;
    rt = e.rt;
    b  = 8'(r >> (8 * e.off));
    h  = 16'(r >> (16 * e.off[1]));
    if (!e.ld) return 32'h0;
    case (e.ty)
      LB:  return {{24{b[7]}}, b};
      LBU: return {24'h0, b};
      LH:  return {{16{h[15]}}, h};
      LHU: return {16'h0, h};
      LW:  return r;
      LWL: return (r << (8 * (3 - e.off))) | (rt & (32'hFFFF_FFFF >> (8 * (e.off + 1))));
      LWR: return (r >> (8 * e.off)) | (rt & ~(32'hFFFF_FFFF >> (8 * e.off)));
      default: return 32'h0;
    endcase
  endfunction

  function automatic int m_unfilled();
    int n = 0;
    foreach (mq[i]) if (!mq[i].filled) n++;
    return n;
  endfunction

  // Reference update for one rising edge, from the inputs held across it.
  task automatic model_update();
    bit ov, acc;
    int total;
    ov  = (mq.size() > 0) && mq[0].filled;
    acc = bus.req_valid && ((mq.size() + m_drop) < DEPTH);
    if (bus.flush) begin
      total = m_drop + m_unfilled() + int'(acc);
      if (bus.data_ok) begin
        if (total > 0) total--;
        else m_perr = 1'b1;
      end
      mq.delete();
      m_drop = total;
    end else begin
      if (bus.data_ok) begin
        if (m_drop > 0) m_drop--;
        else begin
          int idx = -1;
          foreach (mq[i]) if (idx < 0 && !mq[i].filled) idx = i;
          if (idx >= 0) begin
            mq[idx].filled = 1'b1;
            mq[idx].rd     = mq[idx].ld ? bus.rdata : 32'h0;
          end else m_perr = 1'b1;
        end
      end
      if (ov && bus.out_ready) void'(mq.pop_front());
      if (acc) begin
        ment_t e;
        e.ld = bus.req_is_load; e.ty = bus.req_load_type; e.off = bus.req_offset;
        e.rt = bus.req_rt_value; e.we = bus.req_gr_we; e.dest = bus.req_dest;
        e.filled = 1'b0; e.rd = 32'h0;
        mq.push_back(e);
      end
    end
  endtask

  // Compare process: every falling edge outside reset.
  initial begin
    bit mv;
    forever begin
      @(negedge clk);
      if (resetn) begin
        mv = (mq.size() > 0) && mq[0].filled;
        chk("req_ready", bus.req_ready, 32'((mq.size() + m_drop) < DEPTH));
        chk("out_valid", bus.out_valid, 32'(mv));
        chk("outstanding", bus.outstanding, m_unfilled() + m_drop);
        chk("proto_err", bus.proto_err, 32'(m_perr));
        if (mv) begin
          chk("out_result", bus.out_result, m_extract(mq[0]));
          chk("out_gr_we", bus.out_gr_we, 32'(mq[0].we));
          chk("out_dest", bus.out_dest, 32'(mq[0].dest));
        end else begin
          chk("out_result_idle", bus.out_result, 32'h0);
          chk("out_gr_we_idle", bus.out_gr_we, 32'h0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.data_ok   = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic issue(bit ld, bit [6:0] ty, bit [1:0] off, bit [31:0] rt, bit [4:0] dest);
    bus.req_valid     = 1'b1;
    bus.req_is_load   = ld;
    bus.req_load_type = ty;
    bus.req_offset    = off;
    bus.req_rt_value  = rt;
    bus.req_gr_we     = ld;
    bus.req_dest      = dest;
  endtask

  task automatic resp(bit [31:0] d);
    bus.data_ok = 1'b1;
    bus.rdata   = d;
  endtask

  typedef struct {
    bit        ld;
    bit [6:0]  ty;
    bit [1:0]  off;
    bit [31:0] rt;
    bit [31:0] rd;
    bit [31:0] exp;
  } vec_t;
  vec_t vt[6];

  initial begin
    vt[0] = '{1'b1, LWL, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD};
    vt[1] = '{1'b1, LB,  2'd3, 32'h0,         32'h8012_3456, 32'hFFFF_FF80};
    vt[2] = '{1'b1, LHU, 2'd2, 32'h0,         32'hBEEF_0000, 32'h0000_BEEF};
    vt[3] = '{1'b1, LWR, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'hAA11_2233};
    vt[4] = '{1'b1, LH,  2'd0, 32'h0,         32'h0000_8001, 32'hFFFF_8001};
    vt[5] = '{1'b0, LW,  2'd0, 32'h0,         32'hDEAD_BEEF, 32'h0000_0000};

    idle();
    bus.req_is_load = 1'b0; bus.req_load_type = 7'h0; bus.req_offset = 2'd0;
    bus.req_rt_value = 32'h0; bus.req_gr_we = 1'b0; bus.req_dest = 5'd0;
    bus.rdata = 32'h0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 32'h1);
    chk("rst_out_valid", bus.out_valid, 32'h0);
    chk("rst_outstanding", bus.outstanding, 32'h0);
    chk("rst_out_result", bus.out_result, 32'h0);
    chk("rst_out_dest", bus.out_dest, 32'h0);
    chk("rst_proto_err", bus.proto_err, 32'h0);
    resetn = 1'b1;

    // single lw, response two cycles after issue
    issue(1'b1, LW, 2'd0, 32'h0, 5'd3); tick(); idle();
    chk("lw_outstanding", bus.outstanding, 32'h1);
    tick();
    resp(32'h8123_4567); tick(); idle();
    chk("lw_valid", bus.out_valid, 32'h1);
    chk("lw_result", bus.out_result, 32'h8123_4567);
    chk("lw_dest", bus.out_dest, 32'h3);
    bus.out_ready = 1'b1; tick();
    chk("lw_popped_outstanding", bus.outstanding, 32'h0);
    chk("lw_popped_valid", bus.out_valid, 32'h0);

    // extraction / merge vectors
    for (int i = 0; i < 6; i++) begin
      issue(vt[i].ld, vt[i].ty, vt[i].off, vt[i].rt, 5'(i + 10)); tick(); idle();
      resp(vt[i].rd); tick(); idle();
      chk($sformatf("ext%0d_valid", i), bus.out_valid, 32'h1);
      chk($sformatf("ext%0d_result", i), bus.out_result, vt[i].exp);
      tick();
    end

    // fill the queue with backpressure, then drain in order
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, LW, 2'd0, 32'h0, 5'(i + 1)); tick();
    end
    idle();
    chk("full_req_ready", bus.req_ready, 32'h0);
    chk("full_outstanding", bus.outstanding, 32'h4);
    issue(1'b1, LW, 2'd0, 32'h0, 5'd31); tick(); idle();
    for (int i = 0; i < 4; i++) begin
      resp(32'h1000_0000 + i); tick();
    end
    idle();
    chk("full_head_result", bus.out_result, 32'h1000_0000);
    bus.out_ready = 1'b1; tick();
    chk("full_second_result", bus.out_result, 32'h1000_0001);
    bus.out_ready = 1'b0; tick();
    chk("full_hold_result", bus.out_result, 32'h1000_0001);
    bus.out_ready = 1'b1; tick(); tick(); tick();
    chk("full_drained_valid", bus.out_valid, 32'h0);
    chk("full_drained_ready", bus.req_ready, 32'h1);

    // flush with two responses owed
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, LW, 2'd0, 32'h0, 5'(i + 7)); tick();
    end
    idle();
    resp(32'h0000_0011); tick(); idle();
    bus.flush = 1'b1; tick(); idle();
    chk("flush_valid", bus.out_valid, 32'h0);
    chk("flush_outstanding", bus.outstanding, 32'h2);
    resp(32'hBAD0_0001); tick();
    resp(32'hBAD0_0002); tick(); idle();
    chk("drop_valid", bus.out_valid, 32'h0);
    chk("drop_outstanding", bus.outstanding, 32'h0);
    issue(1'b1, LW, 2'd0, 32'h0, 5'd20); tick(); idle();
    resp(32'h5555_AAAA); tick(); idle();
    chk("post_flush_result", bus.out_result, 32'h5555_AAAA);
    tick();

    // flush with same-cycle data_ok and a same-cycle accepted request
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, LW, 2'd0, 32'h0, 5'(i + 1)); tick();
    end
    idle();
    issue(1'b1, LW, 2'd0, 32'h0, 5'd9); resp(32'hBAD0_0003); bus.flush = 1'b1;
    tick(); idle();
    chk("flush2_outstanding", bus.outstanding, 32'h2);
    chk("flush2_valid", bus.out_valid, 32'h0);
    resp(32'hBAD0_0004); tick();
    resp(32'hBAD0_0005); tick(); idle();
    issue(1'b1, LW, 2'd0, 32'h0, 5'd12); tick(); idle();
    resp(32'h600D_F00D); tick(); idle();
    chk("flush2_next_result", bus.out_result, 32'h600D_F00D);
    chk("flush2_next_dest", bus.out_dest, 32'd12);
    tick();

    // stray response, then asynchronous reset mid-operation
    resp(32'h0); tick(); idle();
    chk("stray_proto_err", bus.proto_err, 32'h1);
    tick();
    chk("sticky_proto_err", bus.proto_err, 32'h1);
    issue(1'b1, LW, 2'd0, 32'h0, 5'd4); tick(); idle();
    #2 resetn = 1'b0;
    #1;
    chk("arst_proto_err", bus.proto_err, 32'h0);
    chk("arst_outstanding", bus.outstanding, 32'h0);
    chk("arst_req_ready", bus.req_ready, 32'h1);
    chk("arst_out_valid", bus.out_valid, 32'h0);
    mq.delete(); m_drop = 0; m_perr = 1'b0;
    @(posedge clk); #2 resetn = 1'b1;
    @(negedge clk);
    issue(1'b1, LBU, 2'd1, 32'h0, 5'd6); tick(); idle();
    resp(32'h0000_A500); tick(); idle();
    chk("recover_result", bus.out_result, 32'h0000_00A5);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
